// File: rtl/io_bridge.sv
// Load/store router between the core and data memory / board peripherals.
// Holds every peripheral register: synchronisers, button debounce and events, LEDs and the seven-segment scan.
module io_bridge #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned SCAN_CYCLES     = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IORead,
    input  logic        IOWrite,
    input  logic        MemRead,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    input  logic [15:0] switch,
    input  logic [4:0]  btn,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SC_W    = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCAN_CYCLES - 1);

    localparam logic [7:0] OFF_SW   = 8'h00;
    localparam logic [7:0] OFF_BTN  = 8'h04;
    localparam logic [7:0] OFF_EVT  = 8'h08;
    localparam logic [7:0] OFF_LED  = 8'h10;
    localparam logic [7:0] OFF_DISP = 8'h14;

    logic [15:0]         sw_meta;
    logic [15:0]         sw_sync;
    logic [NUM_BTN-1:0]  btn_meta;
    logic [NUM_BTN-1:0]  btn_sync;
    logic [NUM_BTN-1:0]  btn_db;
    logic [NUM_BTN-1:0]  btn_evt;
    logic [NUM_BTN-1:0]  btn_rise;
    logic [DB_W-1:0]     db_cnt [NUM_BTN];
    logic [31:0]         display;
    logic [SC_W-1:0]     scan_cnt;
    logic [2:0]          idx;
    logic [3:0]          nibble;
    logic [6:0]          hex_seg;

    logic       io_sel;
    logic [7:0] off;
    logic       evt_clr;
    logic       unused_addr;

    assign io_sel      = (addr[31:10] == 22'h3FFFFF);
    assign off         = addr[7:0];
    assign unused_addr = ^addr[9:8];
    // Flags are only consumed (and cleared) when the IO word actually reaches write-back.
    assign evt_clr     = IORead && !MemRead && io_sel && (off == OFF_EVT);

    // Combinational read mux; memory has priority over IO.
    always_comb begin
        rdata = 32'h0;
        if (MemRead) begin
            rdata = mem_rdata;
        end else if (IORead && io_sel) begin
            case (off)
                OFF_SW:   rdata = {16'h0, sw_sync};
                OFF_BTN:  rdata = {27'h0, btn_db};
                OFF_EVT:  rdata = {27'h0, btn_evt};
                OFF_LED:  rdata = {16'h0, led};
                OFF_DISP: rdata = display;
                default:  rdata = 32'h0;
            endcase
        end
    end

    // Input synchronisers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= switch;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    // A debounced 0->1 takes effect on the same edge that sets its event flag.
    always_comb begin
        btn_rise = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            btn_rise[i] = btn_sync[i] && !btn_db[i] && (db_cnt[i] == DB_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_sync[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    btn_db[i] <= btn_sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Sticky events: a new rising edge beats a simultaneous read-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_evt <= '0;
        end else begin
            btn_evt <= (btn_evt & ~{NUM_BTN{evt_clr}}) | btn_rise;
        end
    end

    // Writable IO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led     <= '0;
            display <= '0;
        end else if (IOWrite && io_sel) begin
            if (off == OFF_LED) begin
                led <= wdata[15:0];
            end
            if (off == OFF_DISP) begin
                display <= wdata;
            end
        end
    end

    // Digit scan timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SC_MAX) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SC_W'(1);
        end
    end

    assign nibble = display[{idx, 2'b00} +: 4];

    always_comb begin
        hex_seg = 7'b1000000;
        case (nibble)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            4'hF: hex_seg = 7'b0001110;
            default: hex_seg = 7'b1000000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 8'hFE;
            seg <= 8'hC0;
        end else begin
            an  <= ~(8'b1 << idx);
            seg <= {1'b1, hex_seg};
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Directed self-checking bench for io_bridge (DEBOUNCE_CYCLES=4, SCAN_CYCLES=3).
module tb_io_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        IORead, IOWrite, MemRead;
    logic [31:0] addr, wdata, mem_rdata;
    logic [15:0] switch;
    logic [4:0]  btn;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [7:0]  an, seg;

    int n_cmp = 0;
    int n_bad = 0;

    io_bridge #(.DEBOUNCE_CYCLES(4), .SCAN_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .IORead(IORead), .IOWrite(IOWrite), .MemRead(MemRead),
        .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata), .switch(switch), .btn(btn),
        .rdata(rdata), .led(led), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rst_pulse();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic io_rd(input logic [7:0] o);
        IORead = 1'b1;
        addr   = {24'hFFFFFC, o};
        #1;
    endtask

    task automatic io_wr(input logic [7:0] o, input logic [31:0] d);
        IORead  = 1'b0;
        IOWrite = 1'b1;
        addr    = {24'hFFFFFC, o};
        wdata   = d;
        tick();
        IOWrite = 1'b0;
    endtask

    initial begin
        rst = 1'b1; IORead = 0; IOWrite = 0; MemRead = 0;
        addr = '0; wdata = '0; mem_rdata = '0; switch = '0; btn = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_led", {16'h0, led}, 32'h0);
        chk("reset_an", {24'h0, an}, 32'hFE);
        chk("reset_seg", {24'h0, seg}, 32'hC0);
        chk("reset_rdata", rdata, 32'h0);
        rst = 1'b0;

        // LED write / readback / async reset
        io_wr(8'h10, 32'h1234ABCD);
        chk("led_write", {16'h0, led}, 32'hABCD);
        io_rd(8'h10);
        chk("led_read", rdata, 32'h0000ABCD);
        rst = 1'b1;
        #1;
        chk("led_async_rst", {16'h0, led}, 32'h0);
        rst = 1'b0;

        // Switch synchroniser latency
        switch = 16'h5A5A;
        io_rd(8'h00);
        chk("sw_cycle1", rdata, 32'h0);
        tick();
        chk("sw_cycle2", rdata, 32'h0);
        tick();
        chk("sw_cycle3", rdata, 32'h00005A5A);

        // Memory read path and priority
        IORead = 0; MemRead = 1; addr = 32'h40; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("mem_read", rdata, 32'hDEADBEEF);
        IORead = 1; addr = 32'hFFFFFC00;
        #1;
        chk("mem_priority", rdata, 32'hDEADBEEF);
        MemRead = 0;
        io_rd(8'h0C);
        chk("unmapped_read", rdata, 32'h0);
        addr = 32'h00000010;
        #1;
        chk("non_io_read", rdata, 32'h0);

        // Writes to read-only offsets are ignored
        io_wr(8'h10, 32'h00000F0F);
        io_wr(8'h00, 32'hFFFFFFFF);
        chk("ro_write_led", {16'h0, led}, 32'h0F0F);
        io_rd(8'h00);
        chk("ro_write_sw", rdata, 32'h00005A5A);
        io_rd(8'h14);
        chk("ro_write_disp", rdata, 32'h0);

        // Short glitch is filtered
        io_rd(8'h04);
        btn = 5'b00001;
        repeat (2) tick();
        btn = 5'b0;
        repeat (6) tick();
        chk("glitch_db", rdata, 32'h0);
        io_rd(8'h08);
        chk("glitch_evt", rdata, 32'h0);

        // Long press: level and event
        io_rd(8'h04);
        btn = 5'b00001;
        repeat (10) tick();
        btn = 5'b0;
        chk("press_db", rdata, 32'h1);
        io_rd(8'h08);
        chk("press_evt", rdata, 32'h1);
        tick();
        chk("evt_cleared", rdata, 32'h0);
        io_rd(8'h04);
        repeat (8) tick();
        chk("release_db", rdata, 32'h0);

        // Rising edge on the clear edge keeps the flag
        btn = 5'b00001;
        repeat (5) tick();
        io_rd(8'h08);
        chk("pre_set_evt", rdata, 32'h0);
        tick();
        chk("set_wins", rdata, 32'h1);
        IORead = 0;
        btn = 5'b0;
        io_wr(8'h08, 32'h0);
        io_rd(8'h08);
        chk("evt_write_ignored", rdata, 32'h1);
        rst_pulse();
        #1;
        chk("evt_rst", rdata, 32'h0);
        IORead = 0;

        // Display scan from a known phase
        rst_pulse();
        io_wr(8'h14, 32'h0000F0A1);
        io_rd(8'h14);
        chk("disp_read", rdata, 32'h0000F0A1);
        IORead = 0;
        tick();
        chk("d0_an", {24'h0, an}, 32'hFE);
        chk("d0_seg", {24'h0, seg}, 32'hF9);
        tick();
        chk("d0_an_hold", {24'h0, an}, 32'hFE);
        tick();
        chk("d1_an", {24'h0, an}, 32'hFD);
        chk("d1_seg", {24'h0, seg}, 32'h88);
        repeat (3) tick();
        chk("d2_an", {24'h0, an}, 32'hFB);
        chk("d2_seg", {24'h0, seg}, 32'hC0);
        repeat (3) tick();
        chk("d3_an", {24'h0, an}, 32'hF7);
        chk("d3_seg", {24'h0, seg}, 32'h8E);
        repeat (12) tick();
        chk("d7_an", {24'h0, an}, 32'h7F);
        chk("d7_seg", {24'h0, seg}, 32'hC0);
        repeat (3) tick();
        chk("wrap_an", {24'h0, an}, 32'hFE);
        chk("wrap_seg", {24'h0, seg}, 32'hF9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Memory/IO routing stage directly downstream of the instruction decoder; consumes its IORead, IOWrite and MemRead strobes plus the ALU-computed address.
- Steers loads/stores to data memory or to board peripherals: switches, buttons, LEDs, 8-digit seven-segment display.
- Returns the selected read word to the register write-back mux.
- Owns all peripheral state: input synchronisers, button debounce, sticky button events, LED/display registers, display scan counter.

Parameters:
- DEBOUNCE_CYCLES, 20000, consecutive stable cycles required before a debounced button changes state.
- SCAN_CYCLES, 100000, clock cycles each display digit is driven before advancing.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- IORead  in  1  load targets IO space.
- IOWrite  in  1  store targets IO space.
- MemRead  in  1  load targets data memory.
- addr  in  32  ALU result (byte address).
- wdata  in  32  store data from rs2.
- mem_rdata  in  32  data memory read word.
- switch  in  16  raw board switches (asynchronous).
- btn  in  5  raw push buttons (asynchronous, active-high).
- rdata  out  32  word to write-back mux.
- led  out  16  LED drive.
- an  out  8  digit enables, active-low, one-hot.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. All flops clear on rst assertion, independent of clk.
- IO space is addr[31:10] == 22'h3FFFFF. Register offset = addr[7:0].
  - 0x00: switches, read-only, {16'b0, sw_sync}.
  - 0x04: debounced button level, read-only, {27'b0, btn_db}.
  - 0x08: button event flags, read-to-clear, {27'b0, btn_evt}.
  - 0x10: LED register, R/W; writes take wdata[15:0].
  - 0x14: display value, R/W, 32 bits.
  - Any other offset reads 0; writes to it are ignored.
- Read path is combinational, zero latency:
  - rdata = mem_rdata if MemRead.
  - Otherwise the selected IO register if IORead.
  - Otherwise 0.
  - MemRead and IORead are mutually exclusive; if both are high, MemRead wins.
- IO writes commit on the rising edge where IOWrite=1. The new value is visible on led/rdata the following cycle.
- Writes to read-only offsets (0x00, 0x04, 0x08) are ignored and do not clear flags.
- Switches: 2-flop synchroniser; sw_sync lags switch by 2 cycles.
- Buttons, per bit:
  - 2-flop synchroniser, then debounce counter.
  - Counter resets to 0 whenever the synced value equals btn_db.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, btn_db takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles never reaches btn_db.
- Events: a 0->1 transition of btn_db[i] sets btn_evt[i].
  - A cycle with IORead=1 at offset 0x08 returns the current flags and clears all bits at that clock edge.
  - A rising edge in the same cycle as a clear leaves that bit set (set wins).
- Display scan:
  - Counter runs 0..SCAN_CYCLES-1; at wrap, digit index (3 bits) increments, wrapping 7->0.
  - an = ~(8'b1 << idx).
  - Digit idx shows nibble display[4*idx+3:4*idx] as hex, active-low.
  - Encodings {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - dp (seg[7]) is always 1.
  - an/seg are registered; they update one cycle after idx changes.
- Reset values:
  - led=0, display=0, btn_db=0, btn_evt=0, synchronisers=0.
  - Scan counter=0, idx=0, an=8'hFE, seg=8'hC0.
  - rdata follows the combinational rule.
- Reset mid-operation: a debounce in progress is discarded; pending events are lost; the display restarts at digit 0.

Test Plan:
- Use DEBOUNCE_CYCLES=4 and SCAN_CYCLES=3 for all scenarios.
- IOWrite, addr=0xFFFFFC10, wdata=0x1234ABCD -> led=0xABCD next cycle; IORead at same addr -> rdata=0x0000ABCD; rst pulse -> led=0 immediately, without waiting for a clock edge.
- switch=0x5A5A, then IORead addr=0xFFFFFC00 -> rdata=0 for the first 2 cycles, 0x00005A5A from cycle 3.
- MemRead, addr=0x00000040, mem_rdata=0xDEADBEEF -> rdata=0xDEADBEEF; IOWrite at offset 0x00 -> no state change.
- btn[0] high for 2 cycles -> btn_db and btn_evt stay 0; high for 10 cycles -> btn_db[0]=1 and btn_evt[0]=1; read 0x08 -> rdata=1, then 0 next read; rising edge during clear cycle -> bit stays 1.
- Write 0x0000F0A1 to 0x14 -> an cycles FE,FD,FB,... every 3 cycles; seg=F9 (digit 0, "1"), 88 (digit 1, "A"), C0 (digit 2, "0"), 8E (digit 3, "F"); idx wraps 7->0.
